// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the fetch/data memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF     = 16;
  localparam int DATA_W_DEF     = 16;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE_I,
    DONE_D
  } arbState_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating counter of consecutive data grants taken while fetch was waiting.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX = STARVE_MAX_DEF,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  assign sat = (cnt == W'(MAX));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Grants the unified memory to fetch or data one access at a time (data first,
// fetch protected by a starvation guard) and runs the memory handshake.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  arbState_e        state;
  arbState_e        nextState;
  logic             grantI;
  logic             grantD;
  logic             fetchWaiting;
  logic             accessEnd;
  logic [CNT_W-1:0] starveCnt;
  logic             starveSat;

  // A halted fetch is not competing, so it neither wins nor counts as starved.
  assign fetchWaiting = if_req & ~halt;
  assign accessEnd    = mem_ready & ((state == BUSY_I) | (state == BUSY_D));

  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

  mem_arb_starve_ctr #(
    .MAX (STARVE_MAX),
    .W   (CNT_W)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (grantD & fetchWaiting),
    .clr (grantI | (grantD & ~if_req)),
    .cnt (starveCnt),
    .sat (starveSat)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    nextState = state;
    grantI    = 1'b0;
    grantD    = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req && !(fetchWaiting && starveSat)) begin
          grantD    = 1'b1;
          nextState = BUSY_D;
        end else if (fetchWaiting) begin
          grantI    = 1'b1;
          nextState = BUSY_I;
        end
      end
      BUSY_I:  if (mem_ready) nextState = DONE_I;
      BUSY_D:  if (mem_ready) nextState = DONE_D;
      DONE_I,
      DONE_D:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      state   <= nextState;
      if_done <= accessEnd & (state == BUSY_I);
      dm_done <= accessEnd & (state == BUSY_D);

      if (grantI) begin
        mem_en   <= 1'b1;
        mem_wr   <= 1'b0;
        mem_addr <= if_addr;
      end else if (grantD) begin
        mem_en    <= 1'b1;
        mem_wr    <= dm_wr;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end else if (accessEnd) begin
        mem_en <= 1'b0;
        mem_wr <= 1'b0;
      end

      if (accessEnd && state == BUSY_I) if_rdata <= mem_rdata;
      // Writes leave the last data read value visible to the memory stage.
      if (accessEnd && state == BUSY_D && !mem_wr) dm_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst, halt;
  logic          if_req, dm_req, dm_wr, mem_ready;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic          if_done, if_stall, dm_done, dm_stall, mem_en, mem_wr;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the memory, who is reporting done.
  // Owner/doneWho codes: 0 none, 1 fetch, 2 data.
  int            mOwner, mDoneWho, mStarve;
  logic          mWr;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mWdata, mIfRdata, mDmRdata;
  bit            modelValid = 0;
  int            grantLog[$];

  always @(posedge clk) begin
    if (!rst) begin
      mOwner = 0; mDoneWho = 0; mStarve = 0; mWr = 1'b0;
      mAddr = '0; mWdata = '0; mIfRdata = '0; mDmRdata = '0;
      modelValid = 1;
    end else if (mDoneWho != 0) begin
      mDoneWho = 0;
    end else if (mOwner != 0) begin
      if (mem_ready) begin
        if (mOwner == 1) mIfRdata = mem_rdata;
        else if (!mWr)   mDmRdata = mem_rdata;
        mDoneWho = mOwner;
        mOwner   = 0;
      end
    end else if (dm_req && !(if_req && !halt && mStarve == SMAX)) begin
      mOwner = 2; mAddr = dm_addr; mWr = dm_wr; mWdata = dm_wdata;
      if (if_req && !halt) mStarve = (mStarve + 1 > SMAX) ? SMAX : mStarve + 1;
      else if (!if_req)    mStarve = 0;
      grantLog.push_back(2);
    end else if (if_req && !halt) begin
      mOwner = 1; mAddr = if_addr; mWr = 1'b0; mStarve = 0;
      grantLog.push_back(1);
    end
    #1;
    if (modelValid) begin
      check("mem_en",    mem_en,    mOwner != 0);
      check("mem_wr",    mem_wr,    mOwner == 2 && mWr);
      check("mem_addr",  mem_addr,  mAddr);
      check("mem_wdata", mem_wdata, mWdata);
      check("if_done",   if_done,   mDoneWho == 1);
      check("dm_done",   dm_done,   mDoneWho == 2);
      check("if_rdata",  if_rdata,  mIfRdata);
      check("dm_rdata",  dm_rdata,  mDmRdata);
      check("if_stall",  if_stall,  if_req && mDoneWho != 1);
      check("dm_stall",  dm_stall,  dm_req && mDoneWho != 2);
      check("starve_cnt", dut.starveCnt, mStarve);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drain();
    halt = 1'b0;
    mem_ready = 1'b1;
    for (int n = 0; n < 80 && (if_req || dm_req); n++) begin
      step();
      if (if_done) if_req = 1'b0;
      if (dm_done) dm_req = 1'b0;
    end
    check("drain_timeout", if_req || dm_req, 0);
    if_req = 1'b0;
    dm_req = 1'b0;
    mem_ready = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dutGrants[$];
    int cnt, b2b, ifWait, dmWait;
    bit prevEn, prevDone, seenFetchClr;

    rst = 1'b0; halt = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    repeat (3) step();
    check("rst_mem_en", mem_en, 0);
    check("rst_if_done", if_done, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst = 1'b1;
    step();

    // Lone fetch, memory ready in the second busy cycle.
    if_req = 1'b1; if_addr = 16'h0010;
    #1 check("lf_stall_c0", if_stall, 1);
    step();
    check("lf_en_c1", mem_en, 1);
    check("lf_addr_c1", mem_addr, 16'h0010);
    step();
    check("lf_addr_c2", mem_addr, 16'h0010);
    check("lf_stall_c2", if_stall, 1);
    mem_ready = 1'b1; mem_rdata = 16'hA5A5;
    step();
    check("lf_done_c3", if_done, 1);
    check("lf_rdata_c3", if_rdata, 16'hA5A5);
    check("lf_stall_c3", if_stall, 0);
    mem_ready = 1'b0; if_req = 1'b0;
    step();
    check("lf_done_c4", if_done, 0);
    check("lf_en_c4", mem_en, 0);

    // Data write, memory ready at once.
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h1234;
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    step();
    check("dw_wr_c1", mem_wr, 1);
    check("dw_wdata_c1", mem_wdata, 16'h1234);
    check("dw_addr_c1", mem_addr, 16'h0200);
    step();
    check("dw_done_c2", dm_done, 1);
    check("dw_rdata_kept", dm_rdata, 16'h0000);
    dm_req = 1'b0; dm_wr = 1'b0; mem_ready = 1'b0;
    step();
    check("dw_done_c3", dm_done, 0);

    // Contention with the starvation guard.
    grantLog.delete();
    if_req = 1'b1; if_addr = 16'h1000;
    dm_req = 1'b1; dm_addr = 16'h2000; mem_ready = 1'b1;
    prevEn = 1'b0; seenFetchClr = 1'b0;
    for (int n = 0; n < 40 && dutGrants.size() < 7; n++) begin
      step();
      if (mem_en && !prevEn) begin
        dutGrants.push_back(mem_addr == 16'h1000 ? 1 : 2);
        if (mem_addr == 16'h1000 && !seenFetchClr) begin
          check("ct_starve_clr", dut.starveCnt, 0);
          seenFetchClr = 1'b1;
        end
      end
      prevEn = mem_en;
    end
    check("ct_grant_count", dutGrants.size() >= 6, 1);
    for (int i = 0; i < 6; i++) begin
      int exp;
      exp = (i == 4) ? 1 : 2;
      check($sformatf("ct_model_grant%0d", i), (grantLog.size() > i) ? grantLog[i] : 0, exp);
      check($sformatf("ct_dut_grant%0d", i), (dutGrants.size() > i) ? dutGrants[i] : 0, exp);
    end
    drain();

    // Halt blocks fetch grants but not data.
    halt = 1'b1; if_req = 1'b1; if_addr = 16'h3000;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h4000; mem_ready = 1'b1;
    cnt = 0; b2b = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (mem_en && mem_addr == 16'h3000) cnt++;
      if (dm_done) b2b++;
    end
    for (int n = 0; n < 20 && dm_req; n++) begin
      step();
      if (mem_en && mem_addr == 16'h3000) cnt++;
      if (dm_done) dm_req = 1'b0;
    end
    repeat (2) step();
    check("halt_no_fetch", cnt, 0);
    check("halt_data_served", b2b >= 2, 1);
    halt = 1'b0;
    step();
    check("halt_rel_en", mem_en, 1);
    check("halt_rel_addr", mem_addr, 16'h3000);
    step();
    check("halt_rel_done", if_done, 1);
    if_req = 1'b0; mem_ready = 1'b0;
    repeat (2) step();

    // Reset in the middle of a data read.
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h5000;
    step();
    step();
    check("rs_busy", mem_en, 1);
    rst = 1'b0;
    step();
    check("rs_en", mem_en, 0);
    check("rs_done", dm_done, 0);
    check("rs_addr", mem_addr, 0);
    check("rs_if_rdata", if_rdata, 0);
    rst = 1'b1;
    step();
    check("rs_regrant_en", mem_en, 1);
    check("rs_regrant_addr", mem_addr, 16'h5000);
    mem_ready = 1'b1; mem_rdata = 16'h7777;
    step();
    check("rs_done_after", dm_done, 1);
    check("rs_rdata", dm_rdata, 16'h7777);
    dm_req = 1'b0; mem_ready = 1'b0;
    repeat (2) step();

    // Fetch request held through done re-grants; done never doubles up.
    if_req = 1'b1; if_addr = 16'h6000; mem_ready = 1'b1;
    cnt = 0; b2b = 0; prevDone = 1'b0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (if_done) cnt++;
      if (if_done && prevDone) b2b++;
      prevDone = if_done;
    end
    check("held_done_pulses", cnt >= 3, 1);
    check("held_no_b2b", b2b, 0);
    drain();

    // Randomized traffic against the model.
    ifWait = 0; dmWait = 0;
    for (int n = 0; n < 4000; n++) begin
      step();
      rst = ($urandom_range(0, 199) != 0);
      halt = ($urandom_range(0, 19) == 0);
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = DW'($urandom);
      if (if_req && if_done) begin
        if ($urandom_range(0, 1) == 1) if_addr = AW'($urandom);
        else if_req = 1'b0;
      end else if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1'b1; if_addr = AW'($urandom);
      end
      if (dm_req && dm_done) begin
        if ($urandom_range(0, 1) == 1) begin
          dm_wr = 1'($urandom); dm_addr = AW'($urandom); dm_wdata = DW'($urandom);
        end else dm_req = 1'b0;
      end else if (!dm_req && $urandom_range(0, 2) == 0) begin
        dm_req = 1'b1; dm_wr = 1'($urandom); dm_addr = AW'($urandom); dm_wdata = DW'($urandom);
      end
      ifWait = (if_req && !if_done) ? ifWait + 1 : 0;
      dmWait = (dm_req && !dm_done) ? dmWait + 1 : 0;
      if (ifWait > 400 || dmWait > 400) begin
        check("rand_progress_timeout", 1, 0);
        break;
      end
    end
    rst = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
